// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   Issue stage feeding the 32-bit ALU. Captures decoded instructions, resolves
//   source operands against the MEM and WB forwarding buses, and holds up to two
//   entries (head + skid) so that in_ready comes straight from a register.
//   Held entries keep snooping the forwarding buses until they leave.
//
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   flush                   sync discard of all held entries
//   in_valid/in_ready       decode handshake (in_ready registered)
//   in_opcode, in_shamt     ALU control carried with the entry
//   in_rs1/2, in_rs1/2_data source addresses and regfile read data
//   in_imm, in_use_imm      immediate and operand-B select
//   in_rd                   destination register carried with the entry
//   mem_fwd_*, wb_fwd_*     forwarding buses (MEM has priority over WB)
//   out_valid/out_ready     ALU handshake
//   data_operandA/B, ctrl_ALUopcode, ctrl_shiftamt, out_rd   head entry fields
//
// States
//   S_EMPTY | no entries held
//   S_ONE   | head valid, skid empty
//   S_TWO   | head and skid valid, input blocked

module ex_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_opcode,
  input  logic [4:0]         in_shamt,
  input  logic [RADDR_W-1:0] in_rs1,
  input  logic [RADDR_W-1:0] in_rs2,
  input  logic [DATA_W-1:0]  in_rs1_data,
  input  logic [DATA_W-1:0]  in_rs2_data,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic               in_use_imm,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               mem_fwd_en,
  input  logic [RADDR_W-1:0] mem_fwd_rd,
  input  logic [DATA_W-1:0]  mem_fwd_data,
  input  logic               wb_fwd_en,
  input  logic [RADDR_W-1:0] wb_fwd_rd,
  input  logic [DATA_W-1:0]  wb_fwd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  data_operandA,
  output logic [DATA_W-1:0]  data_operandB,
  output logic [4:0]         ctrl_ALUopcode,
  output logic [4:0]         ctrl_shiftamt,
  output logic [RADDR_W-1:0] out_rd
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  // live1/live2: the source is a real register (not x0) and may still be
  // overwritten by a forwarding bus while the entry is held.
  typedef struct packed {
    logic [DATA_W-1:0]  opa;
    logic [DATA_W-1:0]  opb;
    logic [4:0]         opcode;
    logic [4:0]         shamt;
    logic [RADDR_W-1:0] rd;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic               use_imm;
    logic               live1;
    logic               live2;
  } entry_t;

  state_t state_q;
  entry_t head_q, skid_q;
  logic   out_valid_q, in_ready_q;

  entry_t new_d, head_snp_d, skid_snp_d;
  logic   in_fire, out_fire;

  // Bus hit for a register; MEM wins over WB. Returns cur when no bus matches.
  function automatic logic [DATA_W-1:0] bus_val(input logic live,
                                                input logic [RADDR_W-1:0] rs,
                                                input logic [DATA_W-1:0] cur,
                                                input logic m_en,
                                                input logic [RADDR_W-1:0] m_rd,
                                                input logic [DATA_W-1:0] m_data,
                                                input logic w_en,
                                                input logic [RADDR_W-1:0] w_rd,
                                                input logic [DATA_W-1:0] w_data);
    if (live && m_en && (m_rd == rs))      return m_data;
    else if (live && w_en && (w_rd == rs)) return w_data;
    else                                   return cur;
  endfunction

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    new_d         = '0;
    new_d.opcode  = in_opcode;
    new_d.shamt   = in_shamt;
    new_d.rd      = in_rd;
    new_d.rs1     = in_rs1;
    new_d.rs2     = in_rs2;
    new_d.use_imm = in_use_imm;
    new_d.live1   = (in_rs1 != '0);
    new_d.live2   = (in_rs2 != '0);
    // x0 resolves to zero regardless of what the regfile port returns
    new_d.opa = bus_val(new_d.live1, in_rs1, new_d.live1 ? in_rs1_data : '0,
                        mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                        wb_fwd_en, wb_fwd_rd, wb_fwd_data);
    if (in_use_imm) begin
      new_d.opb = in_imm;
    end else begin
      new_d.opb = bus_val(new_d.live2, in_rs2, new_d.live2 ? in_rs2_data : '0,
                          mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                          wb_fwd_en, wb_fwd_rd, wb_fwd_data);
    end

    head_snp_d     = head_q;
    head_snp_d.opa = bus_val(head_q.live1, head_q.rs1, head_q.opa,
                             mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                             wb_fwd_en, wb_fwd_rd, wb_fwd_data);
    head_snp_d.opb = bus_val(head_q.live2 & ~head_q.use_imm, head_q.rs2, head_q.opb,
                             mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                             wb_fwd_en, wb_fwd_rd, wb_fwd_data);

    skid_snp_d     = skid_q;
    skid_snp_d.opa = bus_val(skid_q.live1, skid_q.rs1, skid_q.opa,
                             mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                             wb_fwd_en, wb_fwd_rd, wb_fwd_data);
    skid_snp_d.opb = bus_val(skid_q.live2 & ~skid_q.use_imm, skid_q.rs2, skid_q.opb,
                             mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                             wb_fwd_en, wb_fwd_rd, wb_fwd_data);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      head_q      <= '0;
      skid_q      <= '0;
    end else if (flush) begin
      // entry contents are left as-is; they are invisible once out_valid drops
      state_q     <= S_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            head_q      <= new_d;
            state_q     <= S_ONE;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            head_q <= new_d;
          end else if (in_fire) begin
            head_q      <= head_snp_d;
            skid_q      <= new_d;
            state_q     <= S_TWO;
            in_ready_q  <= 1'b0;
          end else if (out_fire) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
          end else begin
            head_q <= head_snp_d;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            head_q     <= skid_snp_d;
            state_q    <= S_ONE;
            in_ready_q <= 1'b1;
          end else begin
            head_q <= head_snp_d;
            skid_q <= skid_snp_d;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign data_operandA  = head_q.opa;
  assign data_operandB  = head_q.opb;
  assign ctrl_ALUopcode = head_q.opcode;
  assign ctrl_shiftamt  = head_q.shamt;
  assign out_rd         = head_q.rd;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          reset, flush, in_valid, in_ready, in_use_imm;
  logic [4:0]    in_opcode, in_shamt;
  logic [AW-1:0] in_rs1, in_rs2, in_rd, mem_fwd_rd, wb_fwd_rd, out_rd;
  logic [DW-1:0] in_rs1_data, in_rs2_data, in_imm, mem_fwd_data, wb_fwd_data;
  logic          mem_fwd_en, wb_fwd_en, out_valid, out_ready;
  logic [DW-1:0] data_operandA, data_operandB;
  logic [4:0]    ctrl_ALUopcode, ctrl_shiftamt;

  ex_operand_stage #(.DATA_W(DW), .RADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_shamt(in_shamt),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt), .out_rd(out_rd)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_opcode = 0; in_shamt = 0; in_rs1 = 0; in_rs2 = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_use_imm = 0; in_rd = 0;
    mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_en = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
  endtask

  task automatic do_reset();
    idle();
    out_ready = 0;
    reset = 1;
    tick();
    reset = 0;
    #1;
  endtask

  // simple immediate-only entry, identified by opcode and immediate
  task automatic put_imm(input logic [4:0] op, input logic [31:0] imm);
    in_valid = 1; in_opcode = op; in_shamt = op; in_rd = op;
    in_rs1 = 0; in_rs2 = 0; in_use_imm = 1; in_imm = imm;
  endtask

  // ---------------- table vectors: single-entry capture resolution ----------
  typedef struct packed {
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2, imm;
    logic        use_imm;
    logic        m_en; logic [4:0] m_rd; logic [31:0] m_data;
    logic        w_en; logic [4:0] w_rd; logic [31:0] w_data;
    logic [4:0]  opcode;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  vec_t vec[7];

  // ---------------- reference model: queue of entries -----------------------
  typedef struct {
    logic [31:0] opa, opb;
    logic [4:0]  opcode, shamt, rd, rs1, rs2;
    logic        use_imm;
  } m_t;
  m_t mq[$];

  function automatic logic [31:0] m_bus(input logic [4:0] rs, input logic [31:0] cur);
    if (mem_fwd_en && mem_fwd_rd == rs) return mem_fwd_data;
    if (wb_fwd_en && wb_fwd_rd == rs)   return wb_fwd_data;
    return cur;
  endfunction

  function automatic logic [31:0] m_capture(input logic [4:0] rs, input logic [31:0] rf);
    return (rs == 0) ? 32'd0 : m_bus(rs, rf);
  endfunction

  task automatic model_edge();
    m_t  e;
    bit  ofire, ifire;
    ofire = (mq.size() > 0) && out_ready;
    ifire = (mq.size() < 2) && in_valid && !flush;
    if (flush) begin
      mq.delete();
    end else begin
      foreach (mq[i]) begin
        if (mq[i].rs1 != 0) mq[i].opa = m_bus(mq[i].rs1, mq[i].opa);
        if (!mq[i].use_imm && mq[i].rs2 != 0) mq[i].opb = m_bus(mq[i].rs2, mq[i].opb);
      end
      if (ofire) void'(mq.pop_front());
      if (ifire) begin
        e.opa = m_capture(in_rs1, in_rs1_data);
        e.opb = in_use_imm ? in_imm : m_capture(in_rs2, in_rs2_data);
        e.opcode = in_opcode; e.shamt = in_shamt; e.rd = in_rd;
        e.rs1 = in_rs1; e.rs2 = in_rs2; e.use_imm = in_use_imm;
        mq.push_back(e);
      end
    end
  endtask

  initial begin
    vec[0] = '{5'd3, 5'd4, 32'h5, 32'h7, 32'h0, 1'b0, 1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20, 5'd1, 32'h10, 32'h7};
    vec[1] = '{5'd1, 5'd0, 32'h55, 32'h1234, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF, 5'd2, 32'h55, 32'h0};
    vec[2] = '{5'd5, 5'd5, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 5'd5, 32'h99, 1'b1, 5'd5, 32'hBEEF, 5'd3, 32'hBEEF, 32'hBEEF};
    vec[3] = '{5'd2, 5'd6, 32'h11, 32'h22, 32'hCAFE, 1'b1, 1'b1, 5'd6, 32'h77, 1'b0, 5'd0, 32'h0, 5'd4, 32'h11, 32'hCAFE};
    vec[4] = '{5'd9, 5'd10, 32'hA5A5, 32'h5A5A, 32'h0, 1'b0, 1'b0, 5'd9, 32'h1, 1'b0, 5'd10, 32'h2, 5'd5, 32'hA5A5, 32'h5A5A};
    vec[5] = '{5'd8, 5'd12, 32'h3, 32'h4, 32'h0, 1'b0, 1'b1, 5'd7, 32'h1, 1'b1, 5'd8, 32'h600D, 5'd6, 32'h600D, 32'h4};
    vec[6] = '{5'd0, 5'd31, 32'hDEAD, 32'h8, 32'h0, 1'b0, 1'b1, 5'd0, 32'hF00, 1'b1, 5'd31, 32'h31, 5'd7, 32'h0, 32'h31};

    idle();
    out_ready = 0;
    reset = 1;
    #2;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_opA", data_operandA, 32'd0);
    tick();
    reset = 0;

    // table vectors, one entry at a time through an always-ready ALU
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1; in_rs1 = vec[i].rs1; in_rs2 = vec[i].rs2;
      in_rs1_data = vec[i].d1; in_rs2_data = vec[i].d2; in_imm = vec[i].imm;
      in_use_imm = vec[i].use_imm; in_opcode = vec[i].opcode; in_shamt = 5'd2; in_rd = 5'd17;
      mem_fwd_en = vec[i].m_en; mem_fwd_rd = vec[i].m_rd; mem_fwd_data = vec[i].m_data;
      wb_fwd_en = vec[i].w_en; wb_fwd_rd = vec[i].w_rd; wb_fwd_data = vec[i].w_data;
      tick();
      idle();
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_opA", i), data_operandA, vec[i].exp_a);
      chk($sformatf("vec%0d_opB", i), data_operandB, vec[i].exp_b);
      chk($sformatf("vec%0d_opcode", i), {27'd0, ctrl_ALUopcode}, {27'd0, vec[i].opcode});
      chk($sformatf("vec%0d_rd", i), {27'd0, out_rd}, 32'd17);
      tick();
      chk($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
    end

    // reset while two entries are held
    do_reset();
    put_imm(5'd1, 32'h111); tick();
    put_imm(5'd2, 32'h222); tick();
    in_valid = 0;
    chk("t1_two_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t1_two_out_valid", {31'd0, out_valid}, 32'd1);
    #3 reset = 1;
    #1;
    chk("t1_async_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t1_opA", data_operandA, 32'd0);
    chk("t1_opB", data_operandB, 32'd0);
    chk("t1_ctrl", {17'd0, ctrl_ALUopcode, ctrl_shiftamt, out_rd}, 32'd0);
    reset = 0;

    // back-pressure: three entries, only two taken until released
    do_reset();
    put_imm(5'd1, 32'h111); tick();
    chk("t4_ready_after1", {31'd0, in_ready}, 32'd1);
    put_imm(5'd2, 32'h222); tick();
    chk("t4_ready_after2", {31'd0, in_ready}, 32'd0);
    put_imm(5'd3, 32'h333); tick();
    chk("t4_blocked_ready", {31'd0, in_ready}, 32'd0);
    chk("t4_head1_held", {27'd0, ctrl_ALUopcode}, 32'd1);
    chk("t4_head1_opB", data_operandB, 32'h111);
    out_ready = 1;
    tick();
    chk("t4_out2_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_out2_opcode", {27'd0, ctrl_ALUopcode}, 32'd2);
    chk("t4_out2_opB", data_operandB, 32'h222);
    tick();
    in_valid = 0;
    chk("t4_out3_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_out3_opcode", {27'd0, ctrl_ALUopcode}, 32'd3);
    chk("t4_out3_opB", data_operandB, 32'h333);
    tick();
    chk("t4_empty", {31'd0, out_valid}, 32'd0);

    // snoop on a stalled head
    do_reset();
    in_valid = 1; in_opcode = 5'd9; in_rs1 = 5'd7; in_rs1_data = 32'h1;
    in_use_imm = 1; in_imm = 32'h42;
    tick();
    in_valid = 0;
    chk("t5_opA_before", data_operandA, 32'h1);
    wb_fwd_en = 1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'hABCD;
    mem_fwd_en = 1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'h9999;
    tick();
    idle();
    chk("t5_opA_snooped", data_operandA, 32'hABCD);
    chk("t5_opB_imm_kept", data_operandB, 32'h42);
    chk("t5_opcode", {27'd0, ctrl_ALUopcode}, 32'd9);
    tick();
    chk("t5_opA_sticks", data_operandA, 32'hABCD);

    // flush in TWO beats a same-cycle input
    do_reset();
    put_imm(5'd1, 32'h111); tick();
    put_imm(5'd2, 32'h222); tick();
    put_imm(5'd3, 32'h333);
    flush = 1;
    tick();
    flush = 0;
    chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 0;
    tick();
    chk("t6_dropped", {31'd0, out_valid}, 32'd0);

    // randomized traffic against the queue model
    do_reset();
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 40) == 0);
      in_opcode    = 5'($urandom); in_shamt = 5'($urandom); in_rd = 5'($urandom);
      in_rs1       = 5'($urandom_range(0, 3)); in_rs2 = 5'($urandom_range(0, 3));
      in_rs1_data  = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
      in_use_imm   = ($urandom_range(0, 3) == 0);
      mem_fwd_en   = ($urandom_range(0, 2) == 0); mem_fwd_rd = 5'($urandom_range(0, 3));
      mem_fwd_data = $urandom;
      wb_fwd_en    = ($urandom_range(0, 2) == 0); wb_fwd_rd = 5'($urandom_range(0, 3));
      wb_fwd_data  = $urandom;
      @(posedge clock);
      model_edge();
      #1;
      chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
      chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
      if (mq.size() > 0) begin
        chk("rnd_opA", data_operandA, mq[0].opa);
        chk("rnd_opB", data_operandB, mq[0].opb);
        chk("rnd_ctrl", {17'd0, ctrl_ALUopcode, ctrl_shiftamt, out_rd},
            {17'd0, mq[0].opcode, mq[0].shamt, mq[0].rd});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
